// File: rtl/serial_add_ctrl_if.sv
// Operand/result handshake bundle for serial_add_ctrl.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_ctrl_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_OVF_EN
    input  ovf,
`endif
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
`ifdef SERIAL_ADD_OVF_EN
    output ovf,
`endif
    output in_ready, out_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: {cout,sum} = a + b + cin, one bit per cycle.
// Optional signed-overflow flag enabled by defining SERIAL_ADD_OVF_EN.
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  serial_add_ctrl_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             fa_x, fa_y, fa_s, fa_c;
`ifdef SERIAL_ADD_OVF_EN
  logic             ovf_q, ovf_d;
`endif

  // Single full-adder cell shared across all bit positions.
  always_comb begin
    fa_x = a_q[idx_q];
    fa_y = b_q[idx_q];
    fa_s = fa_x ^ fa_y ^ carry_q;
    fa_c = (fa_x & fa_y) | (carry_q & (fa_x ^ fa_y));
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
`ifdef SERIAL_ADD_OVF_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          cout_d  = 1'b0;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q] = fa_s;
        carry_d      = fa_c;
        idx_d        = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          // carry_q here is the carry into the MSB
          cout_d  = fa_c;
`ifdef SERIAL_ADD_OVF_EN
          ovf_d   = carry_q ^ fa_c;
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
`ifdef SERIAL_ADD_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
`ifdef SERIAL_ADD_OVF_EN
  assign bus.ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl (WIDTH=8) against an arithmetic model.
module tb_serial_add_ctrl;
  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  serial_add_ctrl_if #(.WIDTH(WIDTH)) bus ();
  serial_add_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits (bounded) for in_ready, presents operands, then checks latency and result.
  task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic ci, input int hold);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout, c_msb;
    int               n;
    full     = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
    exp_sum  = full[WIDTH-1:0];
    exp_cout = full[WIDTH];
    c_msb    = ((int'(a) % (1 << (WIDTH-1))) + (int'(b) % (1 << (WIDTH-1))) + int'(ci))
               >= (1 << (WIDTH-1));
    n = 0;
    while (!bus.in_ready && n < 50) begin @(negedge clk); n++; end
    chk("in_ready_before_accept", 64'(bus.in_ready), 64'd1);
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.cin = ci;
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("busy_after_accept", 64'(bus.busy), 64'd1);
    n = 0;
    while (!bus.out_valid && n < 4 * WIDTH) begin
      bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom); bus.cin = 1'($urandom);
      @(negedge clk);
      n++;
    end
    chk("latency", 64'(n), 64'(WIDTH));
    chk("sum", 64'(bus.sum), 64'(exp_sum));
    chk("cout", 64'(bus.cout), 64'(exp_cout));
`ifdef SERIAL_ADD_OVF_EN
    chk("ovf", 64'(bus.ovf), 64'(c_msb ^ exp_cout));
`else
    if (c_msb) n = n; // model term only meaningful with the overflow output
`endif
    for (int unsigned k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1; bus.a = WIDTH'($urandom); bus.b = WIDTH'($urandom);
      @(negedge clk);
      chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
      chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
      chk("hold_sum", 64'({bus.cout, bus.sum}), 64'({exp_cout, exp_sum}));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("idle_after_handshake", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.cin = 1'b0; bus.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    chk("reset_result", 64'({bus.cout, bus.sum}), 64'd0);

    run_op(8'h5A, 8'h3C, 1'b0, 0);
    run_op(8'hFF, 8'h00, 1'b1, 0);
    run_op(8'h7F, 8'h01, 1'b0, 0);
    run_op(8'h80, 8'h80, 1'b0, 20);
    // accepted on the edge right after the handshake
    run_op(8'h01, 8'hFE, 1'b1, 0);

    // Reset at the 4th RUN edge abandons the operation.
    bus.in_valid = 1'b1; bus.a = 8'h33; bus.b = 8'h44; bus.cin = 1'b1;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk("rst_no_edge_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_mid_flags", 64'({bus.in_ready, bus.out_valid, bus.busy}), 64'b100);
    chk("rst_mid_result", 64'({bus.cout, bus.sum}), 64'd0);
    begin
      int seen = 0;
      for (int unsigned k = 0; k < WIDTH + 4; k++) begin
        @(negedge clk);
        if (bus.out_valid) seen++;
      end
      chk("no_result_after_reset", 64'(seen), 64'd0);
    end

    for (int i = 0; i < 30; i++)
      run_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
